// File: rtl/uart_tx_fifo.sv
// UART transmitter with a power-of-two TX FIFO, programmable bit prescaler,
// optional even/odd parity and one or two stop bits; frames go out back-to-back.
module uart_tx_fifo #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [DATA_WIDTH-1:0]            P_DATA,
    input  logic                             Data_Valid,
    output logic                             Data_Ready,
    input  logic                             PAR_EN,
    input  logic                             PAR_TYP,
    input  logic                             STOP2,
    input  logic [PRESCALE_WIDTH-1:0]        PRESCALE,
    output logic                             TX_OUT,
    output logic                             BUSY,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  FIFO_COUNT
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BW = $clog2(DATA_WIDTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [DATA_WIDTH-1:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_rd_ptr;
    logic [CW-1:0]             r_count;
    logic [2:0]                r_state;
    logic [PRESCALE_WIDTH-1:0] r_timer;
    logic [PRESCALE_WIDTH-1:0] r_presc;
    logic [DATA_WIDTH-1:0]     r_shift;
    logic [BW-1:0]             r_bit_idx;
    logic                      r_par_en;
    logic                      r_parity;
    logic                      r_stop2;
    logic                      r_stop_second;
    logic                      r_tx;
    logic                      r_busy;

    logic                      w_push;
    logic                      w_pop;
    logic                      w_last_tick;
    logic                      w_frame_end;
    logic [DATA_WIDTH-1:0]     w_head;
    logic [PRESCALE_WIDTH-1:0] w_presc_eff;

    assign Data_Ready  = (r_count < CW'(FIFO_DEPTH));
    assign w_push      = Data_Valid && Data_Ready;
    assign w_last_tick = (r_timer == r_presc - PRESCALE_WIDTH'(1));
    assign w_frame_end = (r_state == ST_STOP) && w_last_tick && (!r_stop2 || r_stop_second);
    // A pop always coincides with a frame start, either from idle or at the end of a stop bit.
    assign w_pop       = (r_count != '0) && ((r_state == ST_IDLE) || w_frame_end);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_presc_eff = (PRESCALE == '0) ? PRESCALE_WIDTH'(1) : PRESCALE;

    assign TX_OUT     = r_tx;
    assign BUSY       = r_busy;
    assign FIFO_COUNT = r_count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= P_DATA;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_presc       <= PRESCALE_WIDTH'(1);
            r_shift       <= '0;
            r_bit_idx     <= '0;
            r_par_en      <= 1'b0;
            r_parity      <= 1'b0;
            r_stop2       <= 1'b0;
            r_stop_second <= 1'b0;
            r_tx          <= 1'b1;
            r_busy        <= 1'b0;
        end else if (w_pop) begin
            r_state       <= ST_START;
            r_timer       <= '0;
            r_presc       <= w_presc_eff;
            r_shift       <= w_head;
            r_bit_idx     <= '0;
            r_par_en      <= PAR_EN;
            r_parity      <= (^w_head) ^ PAR_TYP;
            r_stop2       <= STOP2;
            r_stop_second <= 1'b0;
            r_tx          <= 1'b0;
            r_busy        <= 1'b1;
        end else if (r_state != ST_IDLE) begin
            if (!w_last_tick) begin
                r_timer <= r_timer + PRESCALE_WIDTH'(1);
            end else begin
                r_timer <= '0;
                case (r_state)
                    ST_START: begin
                        r_state   <= ST_DATA;
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= '0;
                    end
                    ST_DATA: begin
                        if (r_bit_idx == BW'(DATA_WIDTH - 1)) begin
                            r_state <= r_par_en ? ST_PARITY : ST_STOP;
                            r_tx    <= r_par_en ? r_parity : 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + BW'(1);
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                    ST_PARITY: begin
                        r_state <= ST_STOP;
                        r_tx    <= 1'b1;
                    end
                    ST_STOP: begin
                        if (r_stop2 && !r_stop_second) begin
                            r_stop_second <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based frame-waveform model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] p_data = '0;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic          stop2 = 1'b0;
    logic [15:0]   prescale = 16'd1;
    logic          tx_out;
    logic          busy;
    logic [2:0]    fifo_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    uart_tx_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PRESCALE_WIDTH(16)) dut (
        .CLK        (clk),
        .RST        (rst),
        .P_DATA     (p_data),
        .Data_Valid (data_valid),
        .Data_Ready (data_ready),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .STOP2      (stop2),
        .PRESCALE   (prescale),
        .TX_OUT     (tx_out),
        .BUSY       (busy),
        .FIFO_COUNT (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO contents plus the remaining per-cycle line waveform of the frame in flight.
    logic [DW-1:0] m_fifo[$];
    logic          m_wave[$];
    int            m_sz;

    task automatic start_frame(input logic [DW-1:0] w);
        int p;
        logic bits[$];
        p = (prescale == 0) ? 1 : int'(prescale);
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(w[i]);
        if (par_en) bits.push_back((^w) ^ par_typ);
        bits.push_back(1'b1);
        if (stop2) bits.push_back(1'b1);
        foreach (bits[b]) for (int k = 0; k < p; k++) m_wave.push_back(bits[b]);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_fifo.delete();
            m_wave.delete();
        end else begin
            m_sz = m_fifo.size();
            if (m_wave.size() > 1) begin
                void'(m_wave.pop_front());
            end else begin
                m_wave.delete();
                if (m_sz > 0) start_frame(m_fifo.pop_front());
            end
            if (data_valid && m_sz < DEPTH) m_fifo.push_back(p_data);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_out", int'(tx_out), (m_wave.size() > 0) ? int'(m_wave[0]) : 1);
            check("busy", int'(busy), (m_wave.size() > 0) ? 1 : 0);
            check("fifo_count", int'(fifo_count), m_fifo.size());
            check("data_ready", int'(data_ready), (m_fifo.size() < DEPTH) ? 1 : 0);
        end
    end

    int run_cnt  = 0;
    int last_run = 0;
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            run_cnt <= run_cnt + 1;
        end else begin
            if (run_cnt != 0) last_run <= run_cnt;
            run_cnt <= 0;
        end
    end

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        @(negedge clk);
        while (!(busy == 1'b0 && fifo_count == 0) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (n >= max_cycles) check("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        @(negedge clk);
        data_valid = 1'b1;
        p_data     = d;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    int seq1[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    int seq2[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};

    initial begin
        int lows;
        int n;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        check("rst_tx", int'(tx_out), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_ready", int'(data_ready), 1);

        // 0xA5, P=4, even parity, one stop
        prescale = 16'd4; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0;
        push_word(8'hA5);
        check("t1_tx_before_start", int'(tx_out), 1);
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            check("t1_tx", int'(tx_out), seq1[i / 4]);
            check("t1_busy", int'(busy), 1);
        end
        @(negedge clk);
        check("t1_busy_end", int'(busy), 0);

        // 0x00, P=2, odd parity, two stops
        wait_idle(100);
        prescale = 16'd2; par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b1;
        push_word(8'h00);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            check("t2_tx", int'(tx_out), seq2[i / 2]);
        end
        @(negedge clk);
        check("t2_busy_end", int'(busy), 0);

        // Six words offered on consecutive cycles, P=1, no parity
        wait_idle(100);
        prescale = 16'd1; par_en = 1'b0; stop2 = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 6) begin
                check("t3_full_count", int'(fifo_count), 4);
                check("t3_full_ready", int'(data_ready), 0);
            end
            data_valid = 1'b1;
            p_data     = DW'(i);
        end
        @(negedge clk);
        data_valid = 1'b0;
        wait_idle(200);
        check("t3_busy_run", last_run, 50);

        // Push refused while full even on the cycle a pop happens
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            data_valid = 1'b1;
            p_data     = DW'(8'h10 + i);
        end
        n = 0;
        @(negedge clk);
        while (fifo_count == 4 && n < 40) begin
            check("t4_ready_low", int'(data_ready), 0);
            p_data = 8'h77;
            @(negedge clk);
            n++;
        end
        check("t4_count_dec", int'(fifo_count), 3);
        data_valid = 1'b0;
        wait_idle(200);

        // Reset mid-DATA with three words queued
        prescale = 16'd4; par_en = 1'b1; stop2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            data_valid = 1'b1;
            p_data     = DW'(8'h5A ^ i);
        end
        @(negedge clk);
        data_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_queued", int'(fifo_count), 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_tx", int'(tx_out), 1);
        check("t5_busy", int'(busy), 0);
        check("t5_count", int'(fifo_count), 0);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx_out !== 1'b1) lows++;
        end
        check("t5_line_quiet", lows, 0);

        // PRESCALE=0 acts as 1
        prescale = 16'd0; par_en = 1'b0; stop2 = 1'b0;
        push_word(8'h3C);
        wait_idle(100);
        check("t6_presc0_run", last_run, 10);

        // PRESCALE change mid-frame only affects the next frame
        prescale = 16'd3;
        @(negedge clk);
        data_valid = 1'b1; p_data = 8'hC3;
        @(negedge clk);
        p_data = 8'h81;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (8) @(negedge clk);
        prescale = 16'd5;
        wait_idle(300);
        check("t6_presc_change_run", last_run, 80);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            data_valid = ($urandom_range(0, 99) < 40);
            p_data     = DW'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                par_en   = 1'($urandom);
                par_typ  = 1'($urandom);
                stop2    = 1'($urandom);
                prescale = 16'($urandom_range(0, 3));
            end
            rst = ($urandom_range(0, 799) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        data_valid = 1'b0;
        wait_idle(400);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
